// File: rtl/irq_ctl.sv
// Memory-mapped 8-source interrupt controller for the 65C02 bus: synchronises
// sources, latches edge/level requests, masks them and drives a registered IRQ.
module irq_ctl #(
  parameter logic [15:0] BASE        = 16'hFE00,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        RST,
  input  logic [15:0] AD,
  input  logic [7:0]  DO,
  input  logic        WE,
  input  logic        RDY,
  input  logic [7:0]  src,
  output logic        IRQ,
  output logic [7:0]  rd_data,
  output logic        hit
);

  typedef enum logic [1:0] {
    REG_STATUS = 2'd0,
    REG_ENABLE = 2'd1,
    REG_EDGE   = 2'd2,
    REG_VECTOR = 2'd3
  } reg_idx_e;

  logic [7:0] sync_q [SYNC_STAGES];
  logic [7:0] sn;
  logic [7:0] prev_q;
  logic [7:0] rise;
  logic [7:0] pending_q;
  logic [7:0] pending_d;
  logic [7:0] enable_q;
  logic [7:0] edge_q;
  logic [7:0] active;
  logic [7:0] clear;
  logic [7:0] vector;
  logic [7:0] rd_mux;
  logic       found;
  logic       sel;
  logic       wr_en;
  logic       rd_en;
  reg_idx_e   idx;

  assign sn     = sync_q[SYNC_STAGES-1];
  assign rise   = sn & ~prev_q;
  assign active = pending_q & enable_q;
  assign sel    = (AD[15:2] == BASE[15:2]);
  assign idx    = reg_idx_e'(AD[1:0]);
  assign wr_en  = sel & WE & RDY;
  assign rd_en  = sel & ~WE;
  assign clear  = (wr_en && idx == REG_STATUS) ? (DO & edge_q) : '0;

  // Fixed priority: bit 0 wins.
  always_comb begin
    vector = 8'h80;
    found  = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (active[i] && !found) begin
        vector = 8'(i);
        found  = 1'b1;
      end
    end
  end

  // A mode change on the EDGE write edge overrides the normal update: bits
  // leaving edge mode drop their latch, bits entering it keep their value.
  always_comb begin
    pending_d = (edge_q & (rise | (pending_q & ~clear))) | (~edge_q & sn);
    if (wr_en && idx == REG_EDGE) begin
      pending_d = pending_d & ~(edge_q & ~DO);
      pending_d = (pending_d & ~(~edge_q & DO)) | (pending_q & ~edge_q & DO);
    end
  end

  always_comb begin
    rd_mux = '0;
    case (idx)
      REG_STATUS: rd_mux = pending_q;
      REG_ENABLE: rd_mux = enable_q;
      REG_EDGE:   rd_mux = edge_q;
      REG_VECTOR: rd_mux = vector;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      prev_q    <= '0;
      pending_q <= '0;
      enable_q  <= '0;
      edge_q    <= '0;
      IRQ       <= 1'b0;
      hit       <= 1'b0;
      rd_data   <= '0;
    end else begin
      sync_q[0] <= src;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_q    <= sn;
      pending_q <= pending_d;
      IRQ       <= |active;
      if (wr_en) begin
        case (idx)
          REG_ENABLE: enable_q <= DO;
          REG_EDGE:   edge_q   <= DO;
          default:    ;
        endcase
      end
      // RDY low freezes the bus-side outputs only; interrupt tracking runs on.
      if (RDY) begin
        hit     <= rd_en;
        rd_data <= rd_en ? rd_mux : '0;
      end
    end
  end

endmodule
